// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// -----------------------------------------------------------------------------
// Shares the register file's single write port between the ALU writeback path
// (single-cycle results) and the LSU writeback path (returning load data).
// It also keeps a scoreboard of destination registers with loads in flight,
// and flags read-after-load hazards on the two decode read addresses.
//
// Optional build macro: WB_STARVE_GUARD_EN
//   Undefined (default): LSU always wins write-port conflicts.
//   Defined: the ALU is forced to win one conflict after STARVE_MAX
//            consecutive losses.
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   alu_valid_i/alu_ready_o        ALU writeback handshake
//   alu_rd_i, alu_data_i           ALU destination / result
//   lsu_valid_i/lsu_ready_o        LSU writeback handshake
//   lsu_rd_i, lsu_data_i           LSU destination / load data
//   lsu_issue_i, lsu_issue_rd_i    load issued this cycle, and its destination
//   ar1i, ar2i                     decode read addresses checked for hazards
//   hazard_o                       a read address hits a pending load
//   ar3o, r3o, we3o                registered register-file write port
//   pend_o                         scoreboard bit vector (bit r = load pending)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid_i,
    output logic               alu_ready_o,
    input  logic [AW-1:0]      alu_rd_i,
    input  logic [XLEN-1:0]    alu_data_i,
    input  logic               lsu_valid_i,
    output logic               lsu_ready_o,
    input  logic [AW-1:0]      lsu_rd_i,
    input  logic [XLEN-1:0]    lsu_data_i,
    input  logic               lsu_issue_i,
    input  logic [AW-1:0]      lsu_issue_rd_i,
    input  logic [AW-1:0]      ar1i,
    input  logic [AW-1:0]      ar2i,
    output logic               hazard_o,
    output logic [AW-1:0]      ar3o,
    output logic [XLEN-1:0]    r3o,
    output logic               we3o,
    output logic [2**AW-1:0]   pend_o
);

    // A "real" request targets a register other than r0. Requests to r0 are
    // accepted without consuming the write slot, so they never conflict.
    logic alu_real, lsu_real, conflict;
    logic alu_win;
    logic alu_wr, lsu_wr;

    assign alu_real = alu_valid_i && (alu_rd_i != '0);
    assign lsu_real = lsu_valid_i && (lsu_rd_i != '0);
    assign conflict = alu_real && lsu_real;

`ifdef WB_STARVE_GUARD_EN
    typedef enum logic {PRIO_LSU = 1'b0, PRIO_ALU = 1'b1} state_t;
    localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PRIO_LSU;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // The ALU only "loses" in a real-vs-real conflict it does not win. The
    // loss that brings the count to STARVE_MAX flips priority immediately, so
    // the ALU wins the very next cycle rather than one cycle later.
    always_comb begin
        state_nxt  = state;
        starve_nxt = '0;
        if (conflict && !alu_win) begin
            if (starve_cnt == CW'(STARVE_MAX - 1)) begin
                state_nxt  = PRIO_ALU;
                starve_nxt = '0;
            end else begin
                starve_nxt = starve_cnt + 1'b1;
            end
        end
        // Priority to the ALU lasts for exactly one conflict.
        if (state == PRIO_ALU && conflict)
            state_nxt = PRIO_LSU;
    end

    always_comb begin
        alu_win = (state == PRIO_ALU);
    end
`else
    assign alu_win = 1'b0;
`endif

    // Readiness is forced low while in reset so nothing transfers then.
    assign alu_ready_o = rst && alu_valid_i && (!conflict || alu_win);
    assign lsu_ready_o = rst && lsu_valid_i && (!conflict || !alu_win);

    assign alu_wr = alu_ready_o && alu_real;
    assign lsu_wr = lsu_ready_o && lsu_real;

    // Registered write port; address/data hold when no write is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we3o <= 1'b0;
            ar3o <= '0;
            r3o  <= '0;
        end else if (alu_wr) begin
            we3o <= 1'b1;
            ar3o <= alu_rd_i;
            r3o  <= alu_data_i;
        end else if (lsu_wr) begin
            we3o <= 1'b1;
            ar3o <= lsu_rd_i;
            r3o  <= lsu_data_i;
        end else begin
            we3o <= 1'b0;
        end
    end

    // Load scoreboard. The set is applied after the clear so a new load to the
    // same register issued in the cycle its old data returns stays pending.
    logic [2**AW-1:0] pend_nxt;

    always_comb begin
        pend_nxt = pend_o;
        if (lsu_wr)
            pend_nxt[lsu_rd_i] = 1'b0;
        if (lsu_issue_i && (lsu_issue_rd_i != '0))
            pend_nxt[lsu_issue_rd_i] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pend_o <= '0;
        else
            pend_o <= pend_nxt;
    end

    assign hazard_o = rst && ((pend_o[ar1i] && (ar1i != '0)) ||
                              (pend_o[ar2i] && (ar2i != '0)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 2**AW;

`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid_i = 1'b0, lsu_valid_i = 1'b0, lsu_issue_i = 1'b0;
    logic            alu_ready_o, lsu_ready_o, hazard_o, we3o;
    logic [AW-1:0]   alu_rd_i = '0, lsu_rd_i = '0, lsu_issue_rd_i = '0;
    logic [AW-1:0]   ar1i = '0, ar2i = '0, ar3o;
    logic [XLEN-1:0] alu_data_i = '0, lsu_data_i = '0, r3o;
    logic [NREG-1:0] pend_o;

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .lsu_issue_i(lsu_issue_i), .lsu_issue_rd_i(lsu_issue_rd_i),
        .ar1i(ar1i), .ar2i(ar2i), .hazard_o(hazard_o),
        .ar3o(ar3o), .r3o(r3o), .we3o(we3o), .pend_o(pend_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]   ar;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push(logic [AW-1:0] ar, logic [XLEN-1:0] d);
        wr_t w;
        w.ar = ar;
        w.data = d;
        exp_q.push_back(w);
    endfunction

    // Monitor: every write presented on the port must match the oldest
    // expected write, and no write may ever target r0.
    always @(negedge clk) begin
        if (rst && we3o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got ar3o=%0d r3o=0x%0h, expected no write", ar3o, r3o);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 64'(ar3o), 64'(w.ar));
                chk("wr_data", 64'(r3o), 64'(w.data));
            end
            chk("wr_not_r0", 64'(ar3o != '0), 64'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        lsu_issue_i = 1'b0;
        alu_rd_i = '0;
        lsu_rd_i = '0;
        lsu_issue_rd_i = '0;
    endtask

    initial begin
        // Reset: valids high must still give no readies.
        alu_valid_i = 1'b1; alu_rd_i = 5'd1;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd2;
        ar1i = 5'd1;
        @(negedge clk);
        chk("rst_we3o", 64'(we3o), 64'd0);
        chk("rst_ar3o", 64'(ar3o), 64'd0);
        chk("rst_r3o", 64'(r3o), 64'd0);
        chk("rst_pend", 64'(pend_o), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready_o), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready_o), 64'd0);
        chk("rst_hazard", 64'(hazard_o), 64'd0);
        idle();
        ar1i = '0;
        tick();
        rst = 1'b1;
        tick();

        // ALU only: rd=5, 0xDEADBEEF.
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        push(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("alu_only_ready", 64'(alu_ready_o), 64'd1);
        tick();
        idle();
        @(negedge clk);                              // N+1: monitor sees write
        chk("alu_only_we_n1", 64'(we3o), 64'd1);
        tick();
        @(negedge clk);
        chk("alu_only_we_n2", 64'(we3o), 64'd0);
        chk("hold_ar3o", 64'(ar3o), 64'd5);
        chk("hold_r3o", 64'(r3o), 64'hDEADBEEF);
        tick();

        // Conflict: LSU first, ALU next cycle.
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd4; lsu_data_i = 32'h22;
        push(5'd4, 32'h22);
        push(5'd3, 32'h11);
        @(negedge clk);
        chk("conf_lsu_ready", 64'(lsu_ready_o), 64'd1);
        chk("conf_alu_ready", 64'(alu_ready_o), 64'd0);
        tick();
        lsu_valid_i = 1'b0;
        @(negedge clk);
        chk("conf_alu_ready2", 64'(alu_ready_o), 64'd1);
        tick();
        idle();
        tick();

        // Zero register: ALU rd=0 and LSU rd=7 both accepted, one write.
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h55;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h77;
        push(5'd7, 32'h77);
        @(negedge clk);
        chk("zero_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("zero_lsu_ready", 64'(lsu_ready_o), 64'd1);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("zero_no_extra_we", 64'(we3o), 64'd0);
        tick();

        // Scoreboard set, hazard on both read ports, clear on LSU write.
        lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd9;
        @(negedge clk);
        chk("sb_pend9_before", 64'(pend_o[9]), 64'd0);
        tick();
        idle();
        ar1i = 5'd9;
        @(negedge clk);
        chk("sb_pend9_set", 64'(pend_o[9]), 64'd1);
        chk("sb_hazard_ar1", 64'(hazard_o), 64'd1);
        ar1i = 5'd0; ar2i = 5'd9;
        #1;
        chk("sb_hazard_ar2", 64'(hazard_o), 64'd1);
        ar2i = 5'd8;
        #1;
        chk("sb_no_hazard_other", 64'(hazard_o), 64'd0);
        ar1i = 5'd9; ar2i = 5'd0;
        tick();
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h99;
        push(5'd9, 32'h99);
        @(negedge clk);
        chk("sb_lsu_ready", 64'(lsu_ready_o), 64'd1);
        chk("sb_hazard_same_cycle", 64'(hazard_o), 64'd1);
        tick();
        idle();
        @(negedge clk);
        chk("sb_hazard_cleared", 64'(hazard_o), 64'd0);
        chk("sb_pend9_cleared", 64'(pend_o[9]), 64'd0);
        tick();

        // Same-cycle set and clear of rd=9: set wins.
        lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd9;
        tick();
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'hAA;
        push(5'd9, 32'hAA);
        tick();
        idle();
        @(negedge clk);
        chk("sb_set_wins", 64'(pend_o[9]), 64'd1);
        chk("sb_set_wins_hazard", 64'(hazard_o), 64'd1);
        tick();
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'hBB;
        push(5'd9, 32'hBB);
        tick();
        idle();
        // Issue to r0 is ignored; r0 never hazards.
        lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd0;
        tick();
        idle();
        ar1i = 5'd0;
        @(negedge clk);
        chk("sb_r0_ignored", 64'(pend_o), 64'd0);
        chk("sb_r0_no_hazard", 64'(hazard_o), 64'd0);
        tick();

        // Starvation pattern: both continuously valid with real destinations.
        begin
            logic [XLEN-1:0] ad, ld;
            bit alu_exp;
            ad = 32'hA000;
            ld = 32'hB000;
            for (int i = 0; i < 8; i++) begin
                alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = ad;
                lsu_valid_i = 1'b1; lsu_rd_i = 5'd6; lsu_data_i = ld;
                alu_exp = GUARD && ((i % 4) == 3);
                @(negedge clk);
                chk($sformatf("starve_alu_ready_%0d", i), 64'(alu_ready_o), 64'(alu_exp));
                chk($sformatf("starve_lsu_ready_%0d", i), 64'(lsu_ready_o), 64'(!alu_exp));
                if (alu_exp) push(5'd2, ad);
                else         push(5'd6, ld);
                tick();
                if (alu_exp) ad = ad + 1;
                else         ld = ld + 1;
            end
            idle();
            tick();
            tick();
        end

        // Reset mid-burst: write in flight and a pending load.
        lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd12;
        alu_valid_i = 1'b1; alu_rd_i = 5'd8; alu_data_i = 32'h88;
        tick();
        idle();
        chk("mid_we_before", 64'(we3o), 64'd1);
        chk("mid_pend_before", 64'(pend_o[12]), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_we_async", 64'(we3o), 64'd0);
        chk("mid_pend_async", 64'(pend_o), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (address, data, write-enable) between two writeback sources: ALU (single-cycle results) and LSU (load data returning from memory).
- Keeps a load scoreboard of destination registers with outstanding loads.
- Flags read-after-load hazards on the two decode read addresses so the pipeline can stall.
- Sits between execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of the write port.
- AW, 5, register address width (2**AW registers; register 0 hardwired zero).
- STARVE_MAX, 3, consecutive ALU losses before ALU is forced to win (guard feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- alu_valid_i  in  1  ALU writeback request.
- alu_ready_o  out  1  ALU request accepted this cycle.
- alu_rd_i  in  AW  ALU destination.
- alu_data_i  in  XLEN  ALU result.
- lsu_valid_i  in  1  LSU writeback request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- lsu_rd_i  in  AW  LSU destination.
- lsu_data_i  in  XLEN  load data.
- lsu_issue_i  in  1  a load is issued this cycle.
- lsu_issue_rd_i  in  AW  destination of the issued load.
- ar1i  in  AW  decode read address 1.
- ar2i  in  AW  decode read address 2.
- hazard_o  out  1  a read address hits a pending load.
- ar3o  out  AW  register file write address.
- r3o  out  XLEN  register file write data.
- we3o  out  1  register file write enable.
- pend_o  out  2**AW  scoreboard bit vector.

Behaviour:
- **Reset (rst low, asynchronous):** ar3o=0, r3o=0, we3o=0, pend_o=0, starve counter=0, state=PRIO_LSU. hazard_o, alu_ready_o and lsu_ready_o evaluate to 0 while in reset.
- **Handshake:**
  - A request transfers when valid and ready are both high in the same cycle. Ready is combinational from the valids and the state.
  - Sources hold rd and data stable until accepted.
- **Zero-register requests (rd=0):** always accepted the same cycle, with no write issued and no write slot consumed. An rd=0 request from one source and a real request from the other are both accepted in the same cycle.
- **Write slot:** at most one real (rd≠0) write accepted per cycle. Two real requests means exactly one ready.
- **Arbiter states:**
  - PRIO_LSU (default): LSU wins conflicts.
  - PRIO_ALU: ALU wins one conflict, then returns to PRIO_LSU.
- **Latency:** a request accepted in cycle N appears as we3o=1, ar3o=rd, r3o=data in cycle N+1, registered. With no accept in N, we3o=0 in N+1 and ar3o/r3o hold their previous values.
- **Same-destination conflict:** if both requests are real and target the same rd, the winner writes first. The loser is accepted in a later cycle, so its write lands last.
- **Scoreboard:**
  - lsu_issue_i with lsu_issue_rd_i≠0 sets pend[rd] on the next edge.
  - An accepted LSU write with rd≠0 clears pend[rd].
  - Set and clear of the same rd in one cycle: set wins.
  - Issue with rd=0 is ignored. pend[0] is always 0.
- **Hazard:** hazard_o = (pend[ar1i] and ar1i≠0) or (pend[ar2i] and ar2i≠0). Combinational from current pend, so a write accepted this cycle clears the hazard from the next cycle.
- **Reset mid-operation:** in-flight writes are dropped (we3o forced 0 immediately) and all pending bits are cleared.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle the ALU holds a real request and loses.
  - The counter resets to 0 when the ALU is accepted or alu_valid_i is low.
  - When the counter reaches STARVE_MAX, state moves to PRIO_ALU for the next cycle and the counter returns to 0.
- Not defined: no counter and no PRIO_ALU state; LSU always wins conflicts.

Test Plan:
- Reset release, ALU only: rd=5, data=0xDEADBEEF accepted in cycle N → cycle N+1: we3o=1, ar3o=5, r3o=0xDEADBEEF; cycle N+2: we3o=0.
- Conflict: ALU rd=3/0x11 and LSU rd=4/0x22 both valid → LSU written first (ar3o=4), ALU written next cycle (ar3o=3, r3o=0x11).
- Zero-register: ALU rd=0 with LSU rd=7 valid → both readies high the same cycle; only write is ar3o=7; no write to 0 ever appears.
- Scoreboard: issue load rd=9, then ar1i=9 → hazard_o=1 and pend_o[9]=1. LSU writes rd=9 → hazard_o=0 the cycle after acceptance. Same-cycle issue of rd=9 with LSU accept of rd=9 → pend_o[9] stays 1.
- Starvation (WB_STARVE_GUARD_EN, STARVE_MAX=3): ALU and LSU continuously valid → ALU loses 3 cycles, wins the 4th, then the LSU pattern repeats. Without the macro → ALU never accepted while LSU stays valid.
- Reset mid-burst: assert rst during a pending write with pend_o≠0 → we3o=0 and pend_o=0 immediately, without waiting for a clock edge.
